// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
//   Restoring division on unsigned magnitudes produces one quotient bit per
//   cycle. Sign fixup is applied when the result is registered on entry to
//   DONE. Divide-by-zero and signed overflow return fixed values.
//
//   Build option:
//     DIV_EARLY_OUT_EN - when defined, special cases go IDLE->DONE directly
//                        at the accepting edge. valid is then high in the very
//                        next cycle, and busy is high for that DONE cycle only.
//                        When undefined, special cases take the full
//                        WIDTH+1 latency and return the same values.
//
//   Ports:
//     clk       in   clock, posedge
//     rst       in   asynchronous reset, active-high
//     start     in   request, sampled only in IDLE
//     op        in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//     rs1_data  in   dividend
//     rs2_data  in   divisor
//     rd_in     in   destination index, captured with the request
//     busy      out  high in CALC and DONE
//     valid     out  one-cycle pulse in DONE
//     result    out  quotient or remainder, held until the next result
//     rd_out    out  captured rd_in, held like result
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [DEPTH-1:0] rd_in,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic [DEPTH-1:0] rd_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // state | meaning
    // IDLE  | waiting for start
    // CALC  | one restoring step per cycle, then one fixup cycle (fin_q)
    // DONE  | result registered, valid pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fin_q, fin_d;
    logic             rem_sel_q, rem_sel_d;
    logic [DEPTH-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             special_q, special_d;
    logic [WIDTH-1:0] spec_val_q, spec_val_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [DEPTH-1:0] rd_out_q, rd_out_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic             is_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             div0, ovf, special_in;
    logic [WIDTH-1:0] spec_val_in;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] res_quo, res_rem;

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        is_signed   = ~op[0];
        a_neg       = is_signed & rs1_data[WIDTH-1];
        b_neg       = is_signed & rs2_data[WIDTH-1];
        mag_a       = a_neg ? -rs1_data : rs1_data;
        mag_b       = b_neg ? -rs2_data : rs2_data;
        div0        = (rs2_data == '0);
        ovf         = is_signed & (rs1_data == INT_MIN) & (rs2_data == '1);
        special_in  = div0 | ovf;
        if (div0) begin
            spec_val_in = op[1] ? rs1_data : '1;
        end else begin
            spec_val_in = op[1] ? '0 : INT_MIN;
        end

        // Shift in the next dividend bit, then trial-subtract the divisor.
        // A clear top bit of diff means the subtraction did not underflow.
        shifted = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};

        res_quo = qneg_q ? -quo_q : quo_q;
        res_rem = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

        state_d    = state_q;
        cnt_d      = cnt_q;
        fin_d      = fin_q;
        rem_sel_d  = rem_sel_q;
        rd_d       = rd_q;
        dvs_d      = dvs_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        special_d  = special_q;
        spec_val_d = spec_val_q;
        result_d   = result_q;
        rd_out_d   = rd_out_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_sel_d  = op[1];
                    rd_d       = rd_in;
                    dvs_d      = mag_b;
                    quo_d      = mag_a;
                    rem_d      = '0;
                    qneg_d     = a_neg ^ b_neg;
                    rneg_d     = a_neg;
                    special_d  = special_in;
                    spec_val_d = spec_val_in;
                    cnt_d      = '0;
                    fin_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (special_in) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = spec_val_in;
                        rd_out_d = rd_in;
                    end
`endif
                end
            end
            CALC: begin
                if (fin_q) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    rd_out_d = rd_q;
                    if (special_q) begin
                        result_d = spec_val_q;
                    end else begin
                        result_d = rem_sel_q ? res_rem : res_quo;
                    end
                end else begin
                    if (diff[WIDTH] == 1'b0) begin
                        rem_d = diff;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted;
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d = '0;
                        fin_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                fin_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fin_q      <= 1'b0;
            rem_sel_q  <= 1'b0;
            rd_q       <= '0;
            dvs_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            special_q  <= 1'b0;
            spec_val_q <= '0;
            result_q   <= '0;
            rd_out_q   <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fin_q      <= fin_d;
            rem_sel_q  <= rem_sel_d;
            rd_q       <= rd_d;
            dvs_q      <= dvs_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            special_q  <= special_d;
            spec_val_q <= spec_val_d;
            result_q   <= result_d;
            rd_out_q   <= rd_out_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule
